// File: rtl/c2f_chunk_sched.sv
// rtl/c2f_chunk_sched.sv - CPU->FPGA chunk ring scheduler: doorbell/read pointers, one-at-a-time offer, error flags.
// Optional OFFER watchdog built only when C2F_SCHED_TIMEOUT_EN is defined.
module c2f_chunk_sched #(
  parameter int IDX_NBITS      = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 sysClk,
  input  logic                 sysRst_n,
  input  logic                 enable,
  input  logic                 flush,
  input  logic                 commitValid,
  input  logic [IDX_NBITS:0]   commitPtr,
  output logic [IDX_NBITS-1:0] rdIndex,
  output logic                 chunkValid,
  input  logic                 dtAck,
  output logic [IDX_NBITS:0]   rdPtr,
  output logic                 rdPtrUpdate,
  output logic [IDX_NBITS:0]   fillLevel,
  output logic                 errOverflow,
  output logic                 errTimeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  localparam logic [IDX_NBITS:0] RING = {1'b1, {IDX_NBITS{1'b0}}};

  state_e               state_q;
  logic [IDX_NBITS:0]   wr_ptr_q, wr_ptr_d;
  logic [IDX_NBITS:0]   rd_ptr_q, rd_ptr_d;
  logic [IDX_NBITS:0]   rd_post;
  logic [IDX_NBITS:0]   commit_span;
  logic [IDX_NBITS:0]   fill_q;
  logic                 chunk_valid_q;
  logic                 rd_upd_q;
  logic                 err_ovf_q;
  logic                 ack_take;
  logic                 commit_ok;

  assign fill_q = wr_ptr_q - rd_ptr_q;

  // Flush absorbs any ack, so the commit check then runs against the un-advanced rdPtr.
  always_comb begin
    ack_take    = dtAck && chunk_valid_q && !flush;
    rd_post     = ack_take ? rd_ptr_q + 1'b1 : rd_ptr_q;
    commit_span = commitPtr - rd_post;
    commit_ok   = commitValid && (commit_span <= RING);
    wr_ptr_d    = commit_ok ? commitPtr : wr_ptr_q;
    rd_ptr_d    = flush ? wr_ptr_d : rd_post;
  end

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      chunk_valid_q <= 1'b0;
      rd_upd_q      <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rd_upd_q <= (rd_ptr_d != rd_ptr_q);
      if (commitValid && !commit_ok) err_ovf_q <= 1'b1;
      if (flush) begin
        state_q       <= S_IDLE;
        chunk_valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          S_OFFER: begin
            if (ack_take) begin
              state_q       <= S_GAP;
              chunk_valid_q <= 1'b0;
            end
          end
          S_IDLE, S_GAP: begin
            // GAP holds one cycle so the sync-RAM read of the new rdIndex settles.
            if (enable && fill_q != '0) begin
              state_q       <= S_OFFER;
              chunk_valid_q <= 1'b1;
            end else begin
              state_q       <= S_IDLE;
              chunk_valid_q <= 1'b0;
            end
          end
          default: begin
            state_q       <= S_IDLE;
            chunk_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef C2F_SCHED_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;
  logic        err_tmo_q;

  // Watchdog only flags a stuck consumer; the offered chunk is never skipped.
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      tmo_cnt_q <= '0;
      err_tmo_q <= 1'b0;
    end else if (state_q == S_OFFER && !ack_take && !flush) begin
      tmo_cnt_q <= tmo_cnt_q + 32'd1;
      if (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1)) err_tmo_q <= 1'b1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  assign errTimeout = err_tmo_q;
`else
  assign errTimeout = 1'b0;
`endif

  assign rdIndex     = rd_ptr_q[IDX_NBITS-1:0];
  assign rdPtr       = rd_ptr_q;
  assign chunkValid  = chunk_valid_q;
  assign rdPtrUpdate = rd_upd_q;
  assign fillLevel   = fill_q;
  assign errOverflow = err_ovf_q;

endmodule
